// File: rtl/fm_disp_pkg.sv
// rtl/fm_disp_pkg.sv - shared constants and types for the frequency-meter display scanner
// Contents: active-low segment codes ({g,f,e,d,c,b,a}), digit-slot index type,
// active-low one-hot digit enable codes ({H,D,U}) and the slot-advance helper.
package fm_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    DIG_U = 2'd0,
    DIG_D = 2'd1,
    DIG_H = 2'd2
  } dig_idx_e;

  localparam logic [2:0] EN_U    = 3'b110;
  localparam logic [2:0] EN_D    = 3'b101;
  localparam logic [2:0] EN_H    = 3'b011;
  localparam logic [2:0] EN_NONE = 3'b111;

  // Scan order U -> D -> H -> U.
  function automatic dig_idx_e next_dig(input dig_idx_e cur);
    case (cur)
      DIG_U:   next_dig = DIG_D;
      DIG_D:   next_dig = DIG_H;
      default: next_dig = DIG_U;
    endcase
  endfunction

endpackage

// File: rtl/fm_seg_decode.sv
// rtl/fm_seg_decode.sv - BCD to active-low 7-segment converter
// Ports:
//   bcd_i  [3:0] digit value; 10..15 render as 'E'
//   dash_i       forces a dash regardless of bcd_i
//   seg_o  [6:0] segments {g,f,e,d,c,b,a}, active-low
module fm_seg_decode
  import fm_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/fm_display_scan.sv
// rtl/fm_display_scan.sv - captures the meter result and time-multiplexes a 3-digit 7-segment display
// Parameters: SCAN_DIV cycles per digit slot (>=2), CNT_W slot timer width.
// Optional: define FM_DISP_LZB_EN for leading-zero blanking of H and D.
// Ports:
//   CLK, CLR       clock, synchronous active-high reset
//   QH, QD, QU     BCD digits from the meter latch
//   OVF            overflow flag from the meter latch
//   nDONE          end-of-measurement, active-low; falling edge captures
//   SEG [6:0]      segments {g,f,e,d,c,b,a}, active-low
//   DIG_nEN [2:0]  digit enables {H,D,U}, active-low one-hot
//   VALID          a result has been captured since reset
module fm_display_scan
  import fm_disp_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] QH,
  input  logic [3:0] QD,
  input  logic [3:0] QU,
  input  logic       OVF,
  input  logic       nDONE,
  output logic [6:0] SEG,
  output logic [2:0] DIG_nEN,
  output logic       VALID
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(SCAN_DIV - 1);

  logic             ndone_q;
  logic             arm_q;
  logic [3:0]       cap_h_q, cap_d_q, cap_u_q;
  logic             cap_ovf_q;
  logic             valid_q;
  logic [CNT_W-1:0] timer_q;
  dig_idx_e         dig_q;
  logic [6:0]       seg_q;
  logic [2:0]       nen_q;

  logic             capture;
  logic [3:0]       cap_h_d, cap_d_d, cap_u_d;
  logic             cap_ovf_d;
  logic             valid_d;
  logic [CNT_W-1:0] timer_d;
  dig_idx_e         dig_d;
  logic [3:0]       digit_sel;
  logic [2:0]       en_sel;
  logic             lzb_blank;
  logic             show;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_d;
  logic [2:0]       nen_d;

  // arm_q only sets once nDONE has been seen high after reset, so a nDONE
  // held low across reset release is not mistaken for a falling edge even
  // though the edge-detect register itself resets to 1.
  assign capture = ndone_q & ~nDONE & arm_q;

  always_comb begin
    cap_h_d   = capture ? QH  : cap_h_q;
    cap_d_d   = capture ? QD  : cap_d_q;
    cap_u_d   = capture ? QU  : cap_u_q;
    cap_ovf_d = capture ? OVF : cap_ovf_q;
    valid_d   = valid_q | capture;

    if (timer_q >= TIMER_LAST) begin
      timer_d = '0;
      dig_d   = next_dig(dig_q);
    end else begin
      timer_d = timer_q + CNT_W'(1);
      dig_d   = dig_q;
    end
  end

  // Outputs are registered from the next-state values so that SEG/DIG_nEN
  // describe the current slot/timer and a fresh capture shows the very next cycle.
  always_comb begin
    digit_sel = cap_u_d;
    en_sel    = EN_U;
    case (dig_d)
      DIG_D: begin
        digit_sel = cap_d_d;
        en_sel    = EN_D;
      end
      DIG_H: begin
        digit_sel = cap_h_d;
        en_sel    = EN_H;
      end
      default: begin
        digit_sel = cap_u_d;
        en_sel    = EN_U;
      end
    endcase
  end

`ifdef FM_DISP_LZB_EN
  always_comb begin
    lzb_blank = 1'b0;
    if (!cap_ovf_d) begin
      case (dig_d)
        DIG_H:   lzb_blank = (cap_h_d == 4'd0);
        DIG_D:   lzb_blank = (cap_h_d == 4'd0) && (cap_d_d == 4'd0);
        default: lzb_blank = 1'b0;
      endcase
    end
  end
`else
  assign lzb_blank = 1'b0;
`endif

  fm_seg_decode u_dec (
    .bcd_i  (digit_sel),
    .dash_i (cap_ovf_d),
    .seg_o  (dec_seg)
  );

  // Timer value 0 is the anti-ghosting gap at every digit switch.
  assign show  = valid_d && (timer_d != '0) && !lzb_blank;
  assign seg_d = show ? dec_seg : SEG_OFF;
  assign nen_d = show ? en_sel  : EN_NONE;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ndone_q   <= 1'b1;
      arm_q     <= 1'b0;
      cap_h_q   <= 4'd0;
      cap_d_q   <= 4'd0;
      cap_u_q   <= 4'd0;
      cap_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      timer_q   <= '0;
      dig_q     <= DIG_U;
      seg_q     <= SEG_OFF;
      nen_q     <= EN_NONE;
    end else begin
      ndone_q   <= nDONE;
      arm_q     <= arm_q | nDONE;
      cap_h_q   <= cap_h_d;
      cap_d_q   <= cap_d_d;
      cap_u_q   <= cap_u_d;
      cap_ovf_q <= cap_ovf_d;
      valid_q   <= valid_d;
      timer_q   <= timer_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      nen_q     <= nen_d;
    end
  end

  assign SEG     = seg_q;
  assign DIG_nEN = nen_q;
  assign VALID   = valid_q;

endmodule
